// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment codes (active-low {A..G}, A = bit 6) and capture FSM state encodings
// latency: n/a (constants only)
// backpressure: n/a
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h01;
    localparam logic [6:0] SEG_1     = 7'h4F;
    localparam logic [6:0] SEG_2     = 7'h12;
    localparam logic [6:0] SEG_3     = 7'h06;
    localparam logic [6:0] SEG_4     = 7'h4C;
    localparam logic [6:0] SEG_5     = 7'h24;
    localparam logic [6:0] SEG_6     = 7'h20;
    localparam logic [6:0] SEG_7     = 7'h0F;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h0C;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h60;
    localparam logic [6:0] SEG_C     = 7'h31;
    localparam logic [6:0] SEG_D     = 7'h42;
    localparam logic [6:0] SEG_E     = 7'h30;
    localparam logic [6:0] SEG_F     = 7'h38;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] S_WAIT    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

endpackage

// File: rtl/seven_seg_encoder.sv
// seven_seg_encoder: active-low segment pattern -> hex nibble, with blank / unknown-pattern flags
// latency: combinational
// backpressure: none
// ports: seg_n[6:0] in; nibble[3:0], blank, err out (nibble is 0 whenever blank or err)
module seven_seg_encoder
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       err
);

    always_comb begin
        nibble = 4'h0;
        blank  = 1'b0;
        err    = 1'b0;
        case (seg_n)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: blank  = 1'b1;
            default:   err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_capture.sv
// seven_seg_scan_capture: reads back a multiplexed active-low 7-seg bus into NUM_DIGITS-nibble frames
// latency: last digit's first stable cycle t -> frame_valid from cycle t+SETTLE_CYCLES+1
// backpressure: frame held while frame_valid && !frame_ready; a frame completing then is dropped, overflow set
// ports: clk, rst (sync, active-high); seg_n[6:0], an_n[NUM_DIGITS-1:0] scan bus in;
//        frame_data/frame_blank/frame_err/frame_valid out, frame_ready in; overflow sticky out
module seven_seg_scan_capture
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] frame_data,
    output logic [NUM_DIGITS-1:0]   frame_blank,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    overflow
);

    logic [1:0]              state;
    logic [NUM_DIGITS-1:0]   sel_q;      // latched an_n of the current window (active-low)
    logic [6:0]              seg_q;      // latched seg_n of the current window
    logic [CNT_W-1:0]        cnt;
    logic [NUM_DIGITS-1:0]   mask;
    logic [4*NUM_DIGITS-1:0] slot_data;
    logic [NUM_DIGITS-1:0]   slot_blank;
    logic [NUM_DIGITS-1:0]   slot_err;

    logic [NUM_DIGITS-1:0]   sel_act;
    logic                    one_sel;
    logic                    changed;
    logic                    restart;
    logic                    sample;
    logic                    mask_full;
    logic                    slot_free;
    logic [3:0]              enc_nibble;
    logic                    enc_blank;
    logic                    enc_err;

    // Sampling happens only when seg_n equals seg_q, so the latched copy is what gets encoded.
    seven_seg_encoder u_enc (
        .seg_n  (seg_q),
        .nibble (enc_nibble),
        .blank  (enc_blank),
        .err    (enc_err)
    );

    always_comb begin
        sel_act   = ~an_n;
        // exactly one select low: non-zero and a power of two
        one_sel   = (sel_act != '0) && ((sel_act & (sel_act - NUM_DIGITS'(1))) == '0);
        changed   = (an_n != sel_q) || (seg_n != seg_q);
        sample    = (state == S_SETTLE) && !changed && (cnt == CNT_W'(SETTLE_CYCLES - 1));
        mask_full = &mask;
        slot_free = !frame_valid || frame_ready;
        // restart = evaluate the bus as a fresh window this cycle
        case (state)
            S_WAIT:   restart = 1'b1;
            S_SETTLE: restart = changed;
            S_HOLD:   restart = (an_n != sel_q);
            default:  restart = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_WAIT;
            sel_q <= '1;
            seg_q <= SEG_BLANK;
            cnt   <= '0;
        end else if (restart) begin
            if (one_sel) begin
                sel_q <= an_n;
                seg_q <= seg_n;
                cnt   <= CNT_W'(1);
                state <= S_SETTLE;
            end else begin
                cnt   <= '0;
                state <= S_WAIT;
            end
        end else if (sample) begin
            state <= S_HOLD;
        end else if (state == S_SETTLE) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask        <= '0;
            slot_data   <= '0;
            slot_blank  <= '0;
            slot_err    <= '0;
            frame_data  <= '0;
            frame_blank <= '0;
            frame_err   <= '0;
            frame_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sample && !sel_q[i]) begin
                    slot_data[4*i +: 4] <= enc_nibble;
                    slot_blank[i]       <= enc_blank;
                    slot_err[i]         <= enc_err;
                end
            end

            // a capture landing on the completion cycle starts the next frame
            mask <= (mask_full ? '0 : mask) | (sample ? ~sel_q : '0);

            if (mask_full) begin
                if (slot_free) begin
                    frame_data  <= slot_data;
                    frame_blank <= slot_blank;
                    frame_err   <= slot_err;
                    frame_valid <= 1'b1;
                end else begin
                    overflow    <= 1'b1;
                end
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
module tb_seven_seg_scan_capture;

    localparam int ND = 4;
    localparam int SC = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] frame_data;
    logic [3:0]  frame_blank;
    logic [3:0]  frame_err;
    logic        frame_valid;
    logic        frame_ready;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    logic [23:0] got[$];   // {err, blank, data} of each accepted frame

    // display codes, index = hex value
    logic [6:0] code_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                  7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    always #5 clk = ~clk;

    seven_seg_scan_capture #(.NUM_DIGITS(ND), .SETTLE_CYCLES(SC), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .frame_data  (frame_data),
        .frame_blank (frame_blank),
        .frame_err   (frame_err),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overflow    (overflow)
    );

    always @(negedge clk)
        if (!rst && frame_valid && frame_ready)
            got.push_back({frame_err, frame_blank, frame_data});

    // {err, blank, nibble}
    function automatic logic [5:0] ref_encode(input logic [6:0] c);
        if (c == 7'h7F) return 6'b010000;
        for (int k = 0; k < 16; k++)
            if (code_tab[k] == c) return {2'b00, 4'(k)};
        return 6'b100000;
    endfunction

    function automatic logic [23:0] build(input logic [27:0] codes);
        logic [23:0] f;
        logic [5:0]  e;
        f = '0;
        for (int i = 0; i < ND; i++) begin
            e = ref_encode(codes[7*i +: 7]);
            f[4*i +: 4] = e[3:0];
            f[16 + i]   = e[4];
            f[20 + i]   = e[5];
        end
        return f;
    endfunction

    function automatic logic [6:0] rand_code();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6)  return code_tab[$urandom_range(0, 15)];
        if (r == 6) return 7'h7F;
        return 7'($urandom_range(0, 127));
    endfunction

    // All driving happens just after a rising edge; each call holds for len sampling edges.
    task automatic scan_digit(input int d, input logic [6:0] code, input int len);
        an_n  = ~(4'b0001 << d);
        seg_n = code;
        repeat (len) begin @(posedge clk); #1; end
    endtask

    task automatic idle(input int len);
        an_n  = 4'hF;
        seg_n = 7'h7F;
        repeat (len) begin @(posedge clk); #1; end
    endtask

    task automatic scan4(input logic [27:0] codes, input int len);
        for (int i = 0; i < ND; i++) scan_digit(i, codes[7*i +: 7], len);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        got.delete();
    endtask

    // Edges from the current drive point until frame_valid is seen; -1 on timeout.
    task automatic lat_to_valid(output int k);
        k = 0;
        while (k < 30) begin
            @(posedge clk); k++;
            @(negedge clk);
            if (frame_valid) break;
        end
        if (!frame_valid) k = -1;
        @(posedge clk); #1;
    endtask

    task automatic wait_got(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (got.size() >= n) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (got.size() >= n) ok = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; an_n = 4'hF; seg_n = 7'h7F; frame_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", frame_valid); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        tests++; if ({frame_err, frame_blank, frame_data} !== 24'h0) begin
            fails++; $display("FAIL reset_frame: got %h expected 000000", {frame_err, frame_blank, frame_data});
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_scan();
        int k;
        bit ok;
        do_reset();
        frame_ready = 1'b1;
        scan_digit(0, 7'h4F, SC);
        scan_digit(1, 7'h12, SC);
        scan_digit(2, 7'h06, SC);
        tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL scan_partial_valid: got %b expected 0", frame_valid); end
        an_n = 4'b0111; seg_n = 7'h4C;
        lat_to_valid(k);
        tests++; if (k != SC + 1) begin fails++; $display("FAIL scan_latency: got %0d expected %0d", k, SC + 1); end
        @(negedge clk);
        tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL scan_valid_drop: got %b expected 0", frame_valid); end
        @(posedge clk); #1;
        wait_got(1, 5, ok);
        tests++; if (!ok || got.size() != 1 || got[0] !== 24'h004321) begin
            fails++; $display("FAIL scan_frame: got %h (count %0d) expected 004321", ok ? got[0] : 24'h0, got.size());
        end
        idle(3);
    endtask

    task automatic test_short_window();
        int k;
        do_reset();
        frame_ready = 1'b1;
        scan4({7'h7F, 7'h31, 7'h08, 7'h0C}, SC);   // digit 3 blank gets only... overwritten below
        idle(12);
        got.delete();
        scan_digit(0, 7'h60, SC);
        scan_digit(1, 7'h42, SC);
        scan_digit(2, 7'h30, SC);
        scan_digit(3, 7'h38, SC - 1);
        idle(20);
        tests++; if (frame_valid !== 1'b0 || got.size() != 0) begin
            fails++; $display("FAIL short_window_capture: valid %b frames %0d expected 0/0", frame_valid, got.size());
        end
        an_n = 4'b0111; seg_n = 7'h38;
        lat_to_valid(k);
        tests++; if (k != SC + 1) begin fails++; $display("FAIL short_window_latency: got %0d expected %0d", k, SC + 1); end
        tests++; if (got.size() != 1 || got[0] !== 24'h00FEDB) begin
            fails++; $display("FAIL short_window_frame: got %h expected 00fedb", got.size() ? got[0] : 24'h0);
        end
        idle(3);
    endtask

    task automatic test_glitch();
        int k;
        do_reset();
        frame_ready = 1'b1;
        scan_digit(0, 7'h01, SC);
        scan_digit(2, 7'h24, SC);
        scan_digit(3, 7'h20, SC);
        scan_digit(1, 7'h12, 5);
        seg_n = 7'h06;
        lat_to_valid(k);
        tests++; if (k != SC + 1) begin fails++; $display("FAIL glitch_latency: got %0d expected %0d", k, SC + 1); end
        tests++; if (got.size() != 1 || got[0] !== 24'h006530) begin
            fails++; $display("FAIL glitch_frame: got %h expected 006530", got.size() ? got[0] : 24'h0);
        end
        idle(3);
    endtask

    task automatic test_multi_sel();
        int k;
        do_reset();
        frame_ready = 1'b1;
        scan_digit(0, 7'h4F, SC);
        scan_digit(1, 7'h12, SC);
        scan_digit(2, 7'h06, SC);
        an_n = 4'b1100; seg_n = 7'h00;
        repeat (20) begin @(posedge clk); #1; end
        tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL multi_sel_valid: got %b expected 0", frame_valid); end
        an_n = 4'b0111; seg_n = 7'h4C;
        lat_to_valid(k);
        tests++; if (k != SC + 1) begin fails++; $display("FAIL multi_sel_latency: got %0d expected %0d", k, SC + 1); end
        tests++; if (got.size() != 1 || got[0] !== 24'h004321) begin
            fails++; $display("FAIL multi_sel_frame: got %h expected 004321", got.size() ? got[0] : 24'h0);
        end
        idle(3);
    endtask

    task automatic test_overflow();
        int k;
        do_reset();
        frame_ready = 1'b0;
        scan_digit(0, 7'h01, SC);
        scan_digit(1, 7'h4F, SC);
        scan_digit(2, 7'h12, SC);
        an_n = 4'b0111; seg_n = 7'h06;
        lat_to_valid(k);
        idle(2);
        scan4({7'h00, 7'h0F, 7'h20, 7'h24}, SC);
        idle(6);
        @(negedge clk);
        tests++; if (frame_valid !== 1'b1 || frame_data !== 16'h3210) begin
            fails++; $display("FAIL overflow_hold: valid %b data %h expected 1/3210", frame_valid, frame_data);
        end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_flag: got %b expected 1", overflow); end
        @(posedge clk); #1;
        frame_ready = 1'b1;
        idle(3);
        @(negedge clk);
        tests++; if (frame_valid !== 1'b0 || got.size() != 1 || got[0] !== 24'h003210) begin
            fails++; $display("FAIL overflow_drain: valid %b frames %0d first %h expected 0/1/003210",
                              frame_valid, got.size(), got.size() ? got[0] : 24'h0);
        end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_sticky: got %b expected 1", overflow); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int k;
        do_reset();
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL b2b_overflow_reset: got %b expected 0", overflow); end
        frame_ready = 1'b0;
        scan_digit(0, 7'h08, SC);
        scan_digit(1, 7'h60, SC);
        scan_digit(2, 7'h31, SC);
        an_n = 4'b0111; seg_n = 7'h42;
        lat_to_valid(k);
        scan_digit(0, 7'h30, SC);
        scan_digit(1, 7'h38, SC);
        scan_digit(2, 7'h0C, SC);
        scan_digit(3, 7'h00, SC);   // completion cycle of frame B is the next one
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0;
        @(negedge clk);
        tests++; if (frame_valid !== 1'b1 || frame_data !== 16'h89FE) begin
            fails++; $display("FAIL b2b_load: valid %b data %h expected 1/89fe", frame_valid, frame_data);
        end
        tests++; if (got.size() != 1 || got[0] !== 24'h00DCBA || overflow !== 1'b0) begin
            fails++; $display("FAIL b2b_first: frames %0d first %h overflow %b expected 1/00dcba/0",
                              got.size(), got.size() ? got[0] : 24'h0, overflow);
        end
        @(posedge clk); #1;
        frame_ready = 1'b1;
        idle(3);
        tests++; if (got.size() != 2 || got[got.size()-1] !== 24'h0089FE) begin
            fails++; $display("FAIL b2b_second: frames %0d last %h expected 2/0089fe",
                              got.size(), got.size() ? got[got.size()-1] : 24'h0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        frame_ready = 1'b0;
        scan4({7'h4C, 7'h06, 7'h12, 7'h4F}, SC);
        scan_digit(0, 7'h0F, SC);
        scan_digit(1, 7'h00, SC);
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        tests++; if (frame_valid !== 1'b0 || overflow !== 1'b0 || frame_data !== 16'h0) begin
            fails++; $display("FAIL reset_mid_outputs: valid %b overflow %b data %h expected 0/0/0000",
                              frame_valid, overflow, frame_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        frame_ready = 1'b1;
        scan_digit(2, 7'h24, SC);
        scan_digit(3, 7'h20, SC);
        idle(12);
        tests++; if (got.size() != 0) begin fails++; $display("FAIL reset_mid_partial: frames %0d expected 0", got.size()); end
        scan4({7'h20, 7'h24, 7'h0C, 7'h31}, SC);
        wait_got(1, 20, ok);
        idle(3);
        tests++; if (!ok || got.size() != 1 || got[0] !== 24'h00659C) begin
            fails++; $display("FAIL reset_mid_frame: frames %0d first %h expected 1/00659c",
                              got.size(), got.size() ? got[0] : 24'h0);
        end
    endtask

    task automatic test_encoder();
        logic [27:0] codes;
        logic [23:0] exp [32];
        bit ok;
        do_reset();
        frame_ready = 1'b1;
        for (int f = 0; f < 32; f++) begin
            for (int i = 0; i < ND; i++) codes[7*i +: 7] = 7'(4*f + ((i + f) % 4));
            exp[f] = build(codes);
            scan4(codes, SC);
        end
        wait_got(32, 40, ok);
        tests++; if (!ok) begin fails++; $display("FAIL encoder_count: frames %0d expected 32", got.size()); end
        for (int f = 0; f < 32 && f < got.size(); f++) begin
            tests++;
            if (got[f] !== exp[f]) begin
                fails++; $display("FAIL encoder_frame%0d: got %h expected %h", f, got[f], exp[f]);
            end
        end
        idle(3);
    endtask

    task automatic test_random();
        logic [27:0] codes;
        logic [3:0]  have;
        logic [23:0] exp[$];
        int d, len;
        logic [6:0] c;
        do_reset();
        frame_ready = 1'b1;
        codes = '0; have = '0;
        for (int w = 0; w < 160; w++) begin
            d   = $urandom_range(0, 3);
            len = $urandom_range(2, 12);
            c   = rand_code();
            scan_digit(d, c, len);
            if (len >= SC) begin
                codes[7*d +: 7] = c;
                have[d] = 1'b1;
                if (have == 4'hF) begin exp.push_back(build(codes)); have = '0; end
            end
            idle($urandom_range(1, 2));
        end
        idle(15);
        tests++; if (got.size() != exp.size() || overflow !== 1'b0) begin
            fails++; $display("FAIL random_count: frames %0d overflow %b expected %0d/0", got.size(), overflow, exp.size());
        end
        for (int f = 0; f < exp.size() && f < got.size(); f++) begin
            tests++;
            if (got[f] !== exp[f]) begin
                fails++; $display("FAIL random_frame%0d: got %h expected %h", f, got[f], exp[f]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_short_window();
        test_glitch();
        test_multi_sel();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_encoder();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
